sdram_arb: RTL and testbench
============================

Name: sdram_arb

Overview:
- Two-client request front-end that sits directly upstream of the SDRAM controller.
- Converts level req/ack handshakes from client A (CPU, default priority) and client B (video/loader DMA) into the controller's edge-triggered rd/we strobes.
- Tracks the controller's ready, including the same-word read-hit case where ready never drops.
- Returns read data and a one-cycle ack to the winning client.

Parameters:
- ADDR_W, 25, byte address width passed to controller (addr[0] selects byte in 8-bit mode).
- GUARD, 2, cycles after strobe rise before ready is trusted (controller's ready drop is 1 registered cycle late); legal range 2..7.

Ports:
- clk  in  1  system clock, same clock as SDRAM controller.
- reset_n  in  1  asynchronous, active-low reset.
- a_req  in  1  client A request, level, held until a_ack.
- a_we  in  1  1 = write, 0 = read; sampled at grant.
- a_addr  in  ADDR_W  client A byte address.
- a_din  in  16  client A write data.
- a_wtbt  in  2  client A byte-enable code, passed through to controller.
- a_ack  out  1  one-cycle pulse: access complete; a_dout valid on this cycle.
- a_dout  out  16  client A read data, held until the next A read completes.
- b_req, b_we, b_addr, b_din, b_wtbt, b_ack, b_dout: same as the A group, for client B.
- mem_rd  out  1  read strobe to controller (rising edge starts access).
- mem_we  out  1  write strobe to controller.
- mem_addr  out  ADDR_W  address to controller.
- mem_din  out  16  write data to controller.
- mem_wtbt  out  2  byte-enable code to controller.
- mem_dout  in  16  controller read data; valid while mem_ready=1 after a read.
- mem_ready  in  1  controller ready / dout valid.

Behaviour:
- Reset (async, reset_n=0) values:
  - a_ack=b_ack=0, a_dout=b_dout=0.
  - mem_rd=mem_we=0, mem_addr=0, mem_din=0, mem_wtbt=0.
  - state=IDLE, guard counter=0, owner=A, last_grant=B.
- All outputs are registered.
- IDLE:
  - Wait until mem_ready=1 and at least one req is high.
  - Grant: A wins if a_req=1, else B.
  - On grant:
    - Latch owner.
    - Drive mem_addr/mem_din/mem_wtbt from the winner.
    - Raise mem_rd (we=0) or mem_we (we=1).
    - Load guard counter = GUARD.
    - Go to ISSUE.
  - No grant while mem_ready=0 (covers controller startup after init).
- ISSUE:
  - Strobe held high; decrement guard counter.
  - At 0, go to WAIT.
  - mem_ready is ignored in ISSUE.
- WAIT:
  - Strobe held high.
  - When mem_ready=1:
    - Read: capture mem_dout into the owner's dout register.
    - Pulse owner's ack for 1 cycle (registered, so ack and updated dout appear together on the next cycle).
    - Drop the strobe.
    - Go to DONE.
  - Same-word read hit (controller keeps ready=1): completes on the first WAIT cycle.
    - Minimum latency req-to-ack = GUARD+2 cycles.
- DONE:
  - Strobe low for exactly this cycle; guarantees ≥1 low cycle between accesses so the controller sees a fresh edge.
  - Go to IDLE.
  - The client must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- mem_addr/mem_din/mem_wtbt are stable from grant until the DONE→IDLE transition. The controller samples the address several cycles after the edge.
- Writes complete when the controller reasserts ready on write-command issue; the owner's dout is unchanged.
- Non-owner ack stays 0 throughout an access. Changes on the non-owner's inputs are ignored until the next IDLE.
- Simultaneous a_req and b_req in IDLE: A granted; B waits, no loss.
- mem_ready dropping while in IDLE: no grant until it returns high.
- Reset mid-access:
  - Strobes return low immediately.
  - No ack is generated.
  - The next access after reset release waits for mem_ready=1.

Optional Feature:
- SDRAM_ARB_ROUND_ROBIN_EN
- Defined:
  - When both reqs are high in IDLE, grant the client that did not win the previous grant (last_grant register, reset to B so A wins first).
  - A single requester is always granted immediately.
- Undefined:
  - Fixed priority, A always over B.
  - last_grant is not implemented.

Test Plan:
- Startup gating: hold mem_ready=0, a_req=1 read addr 0x000100 for 50 cycles → mem_rd stays 0. Set mem_ready=1 → mem_rd rises next cycle.
- Normal read: A read 0x000200; model drops mem_ready 1 cycle after the strobe edge and raises it 8 cycles later with mem_dout=0xBEEF → a_ack single pulse, a_dout=0xBEEF, mem_rd low ≥1 cycle, b_ack=0.
- Read hit: model keeps mem_ready=1 and mem_dout=0x1234 → a_ack exactly GUARD+2 cycles after grant (4 at default), a_dout=0x1234.
- Write: B write addr 0x1F0003, din 0x00A5, wtbt 2'b00 → mem_we pulse; mem_addr=0x1F0003, mem_din=0x00A5, mem_wtbt=0 held until DONE; b_ack pulse; b_dout unchanged.
- Contention: a_req and b_req raised in the same cycle, both reads:
  - Without macro: A acked first, then B; re-raising A immediately starves B.
  - With SDRAM_ARB_ROUND_ROBIN_EN: order alternates A, B, A, B.
- Async reset: assert reset_n=0 mid-WAIT → mem_rd=0 in the same cycle; after release, no stale ack, and the next access proceeds normally.

Source files
------------

// File: rtl/sdram_arb_if.sv
// Bus bundle between sdram_arb, its two clients (A = CPU, B = DMA) and the SDRAM controller.
// The slave modport is the arbiter's view; master is the view of whatever drives the clients and models the controller.
interface sdram_arb_if #(
  parameter int ADDR_W = 25
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_din;
  logic [1:0]        a_wtbt;
  logic              a_ack;
  logic [15:0]       a_dout;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_din;
  logic [1:0]        b_wtbt;
  logic              b_ack;
  logic [15:0]       b_dout;

  logic              mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_wtbt;
  logic [15:0]       mem_dout;
  logic              mem_ready;

  modport slave (
    input  a_req, a_we, a_addr, a_din, a_wtbt,
    output a_ack, a_dout,
    input  b_req, b_we, b_addr, b_din, b_wtbt,
    output b_ack, b_dout,
    output mem_rd, mem_we, mem_addr, mem_din, mem_wtbt,
    input  mem_dout, mem_ready
  );

  modport master (
    output a_req, a_we, a_addr, a_din, a_wtbt,
    input  a_ack, a_dout,
    output b_req, b_we, b_addr, b_din, b_wtbt,
    input  b_ack, b_dout,
    input  mem_rd, mem_we, mem_addr, mem_din, mem_wtbt,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/sdram_arb.sv
// Two-client front-end for the SDRAM controller: level req/ack clients in, edge-triggered rd/we strobes out.
// Define SDRAM_ARB_ROUND_ROBIN_EN to alternate grants under contention; default build is fixed A-over-B priority.
//
// Handshake: a client holds req (with we/addr/din/wtbt) until its one-cycle ack; dout is valid with ack.
// A strobe rising edge starts a controller access; ready is ignored for GUARD+1 cycles after the edge.
module sdram_arb #(
  parameter int ADDR_W = 25,
  parameter int GUARD  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  sdram_arb_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] GUARD_INIT = 3'(GUARD);

  state_t            state;
  logic [2:0]        guard_cnt;
  logic              owner;      // 0 = A, 1 = B
  logic              own_we;

  logic              grant_b;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [15:0]       grant_din;
  logic [1:0]        grant_wtbt;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic              last_grant; // 0 = A, 1 = B
`endif

  assign dbg_state = state;

  always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Under contention the client that lost last time wins.
    grant_b = bus.b_req && (!bus.a_req || !last_grant);
`else
    grant_b = bus.b_req && !bus.a_req;
`endif
    grant_we   = grant_b ? bus.b_we   : bus.a_we;
    grant_addr = grant_b ? bus.b_addr : bus.a_addr;
    grant_din  = grant_b ? bus.b_din  : bus.a_din;
    grant_wtbt = grant_b ? bus.b_wtbt : bus.a_wtbt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      guard_cnt    <= '0;
      owner        <= 1'b0;
      own_we       <= 1'b0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.a_dout   <= '0;
      bus.b_dout   <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.mem_wtbt <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      case (state)
        IDLE: begin
          // mem_ready low means the controller is busy or still initialising.
          if (bus.mem_ready && (bus.a_req || bus.b_req)) begin
            owner        <= grant_b;
            own_we       <= grant_we;
            bus.mem_addr <= grant_addr;
            bus.mem_din  <= grant_din;
            bus.mem_wtbt <= grant_wtbt;
            bus.mem_rd   <= !grant_we;
            bus.mem_we   <= grant_we;
            guard_cnt    <= GUARD_INIT;
            state        <= ISSUE;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            last_grant   <= grant_b;
`endif
          end
        end
        ISSUE: begin
          // Controller's ready drop lags the strobe, so ready is stale here.
          if (guard_cnt == 3'd0) state <= WAIT;
          else                   guard_cnt <= guard_cnt - 3'd1;
        end
        WAIT: begin
          if (bus.mem_ready) begin
            if (!own_we) begin
              if (owner) bus.b_dout <= bus.mem_dout;
              else       bus.a_dout <= bus.mem_dout;
            end
            if (owner) bus.b_ack <= 1'b1;
            else       bus.a_ack <= 1'b1;
            bus.mem_rd <= 1'b0;
            bus.mem_we <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          // Strobe is low for this cycle so the next access presents a fresh edge.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: a behavioural controller model answers the strobes,
// per-scenario tasks drive clients and compare against hand-computed values.
module tb_sdram_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // Controller model controls
  bit          model_en   = 1'b0;
  bit          model_hit  = 1'b0;
  int          model_lat  = 8;
  logic [15:0] model_data = 16'h0000;
  logic        ready_cfg  = 1'b0;
  bit          prev_strobe = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;

  sdram_arb_if #(.ADDR_W(25)) bus ();

  sdram_arb #(.ADDR_W(25), .GUARD(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Controller model: reacts 2 time units after each rising edge.
  // Normal access: ready drops 1 cycle after the strobe edge, returns model_lat cycles later with data.
  // Hit access: ready stays high, data presented at the edge.
  always begin
    bit strobe_now;
    @(posedge clk);
    #2;
    strobe_now = bus.mem_rd | bus.mem_we;
    if (!model_en) begin
      bus.mem_ready = ready_cfg;
      bus.mem_dout  = model_data;
      busy = 1'b0;
      cnt  = 0;
    end else if (strobe_now && !prev_strobe) begin
      cnt = 0;
      if (model_hit) begin
        bus.mem_dout  = model_data;
        bus.mem_ready = 1'b1;
        busy = 1'b0;
      end else begin
        busy = 1'b1;
      end
    end else if (busy) begin
      cnt++;
      if (cnt == 1) bus.mem_ready = 1'b0;
      if (cnt == model_lat + 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_dout  = model_data;
        busy = 1'b0;
      end
    end
    prev_strobe = strobe_now;
  end

  // Driver: one client access, held until its ack, with observation of strobe/ack behaviour.
  task automatic do_access(input bit cli, input bit we, input logic [24:0] addr,
                           input logic [15:0] din, input logic [1:0] wtbt,
                           output int lat, output int acks, output int other_acks,
                           output bit rd_low, output bit hold_ok);
    int rise_idx;
    int post;
    bit strobe, own, oth;
    rise_idx = -1; lat = -1; acks = 0; other_acks = 0;
    rd_low = 1'b0; hold_ok = 1'b1; post = -1;
    @(negedge clk);
    if (cli) begin
      bus.b_we = we; bus.b_addr = addr; bus.b_din = din; bus.b_wtbt = wtbt; bus.b_req = 1'b1;
    end else begin
      bus.a_we = we; bus.a_addr = addr; bus.a_din = din; bus.a_wtbt = wtbt; bus.a_req = 1'b1;
    end
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      strobe = bus.mem_rd | bus.mem_we;
      if (strobe && rise_idx < 0) rise_idx = i;
      if (strobe && (bus.mem_addr !== addr || bus.mem_din !== din || bus.mem_wtbt !== wtbt ||
                     bus.mem_we !== we || bus.mem_rd !== !we)) hold_ok = 1'b0;
      own = cli ? bus.b_ack : bus.a_ack;
      oth = cli ? bus.a_ack : bus.b_ack;
      if (oth) other_acks++;
      if (own) begin
        acks++;
        if (acks == 1) begin
          lat    = i - rise_idx;
          rd_low = !strobe;
          if (cli) bus.b_req = 1'b0; else bus.a_req = 1'b0;
          post = 3;
        end
      end
      if (post == 0) break;
      if (post > 0) post--;
    end
    if (cli) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_din = '0; bus.a_wtbt = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_din = '0; bus.b_wtbt = '0;
    repeat (3) @(negedge clk);
    if ({bus.a_ack, bus.b_ack} !== 2'b00) begin
      $display("FAIL reset_ack: got %b want 00", {bus.a_ack, bus.b_ack}); failures++;
    end
    checks++;
    if (bus.a_dout !== 16'h0 || bus.b_dout !== 16'h0) begin
      $display("FAIL reset_dout: got a=%h b=%h want 0", bus.a_dout, bus.b_dout); failures++;
    end
    checks++;
    if ({bus.mem_rd, bus.mem_we} !== 2'b00) begin
      $display("FAIL reset_strobe: got %b want 00", {bus.mem_rd, bus.mem_we}); failures++;
    end
    checks++;
    if (bus.mem_addr !== 25'h0 || bus.mem_din !== 16'h0 || bus.mem_wtbt !== 2'b00) begin
      $display("FAIL reset_mem_bus: got addr=%h din=%h wtbt=%b want 0", bus.mem_addr, bus.mem_din, bus.mem_wtbt);
      failures++;
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL reset_state: got %0d want 0", dbg_state); failures++;
    end
    checks++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_startup_gating();
    int rd_seen;
    bit got_ready, got_ack;
    rd_seen = 0; got_ready = 1'b0; got_ack = 1'b0;
    model_data = 16'h0100;
    bus.a_we = 1'b0; bus.a_addr = 25'h000100; bus.a_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_rd) rd_seen++;
    end
    if (rd_seen !== 0) begin
      $display("FAIL gate_no_strobe: got %0d strobe cycles want 0", rd_seen); failures++;
    end
    checks++;
    ready_cfg = 1'b1;
    for (int i = 0; i < 5 && !got_ready; i++) begin
      @(negedge clk);
      if (bus.mem_ready) got_ready = 1'b1;
    end
    if (bus.mem_rd !== 1'b0) begin
      $display("FAIL gate_same_cycle: got mem_rd=%b want 0", bus.mem_rd); failures++;
    end
    checks++;
    @(negedge clk);
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 25'h000100) begin
      $display("FAIL gate_release: got mem_rd=%b addr=%h want 1 000100", bus.mem_rd, bus.mem_addr); failures++;
    end
    checks++;
    for (int i = 0; i < 20 && !got_ack; i++) begin
      @(negedge clk);
      if (bus.a_ack) begin got_ack = 1'b1; bus.a_req = 1'b0; end
    end
    bus.a_req = 1'b0;
    if (!got_ack || bus.a_dout !== 16'h0100) begin
      $display("FAIL gate_complete: got ack=%b dout=%h want 1 0100", got_ack, bus.a_dout); failures++;
    end
    checks++;
    repeat (2) @(negedge clk);
    model_en = 1'b1;
  endtask

  task automatic test_read();
    int lat, acks, oth; bit rd_low, hold_ok;
    model_hit = 1'b0; model_lat = 8; model_data = 16'hBEEF;
    do_access(1'b0, 1'b0, 25'h000200, 16'h0000, 2'b11, lat, acks, oth, rd_low, hold_ok);
    if (acks !== 1 || oth !== 0) begin
      $display("FAIL read_acks: got a=%0d b=%0d want 1 0", acks, oth); failures++;
    end
    checks++;
    if (bus.a_dout !== 16'hBEEF) begin
      $display("FAIL read_dout: got %h want beef", bus.a_dout); failures++;
    end
    checks++;
    if (lat !== 10 || !rd_low || !hold_ok) begin
      $display("FAIL read_timing: got lat=%0d rd_low=%b hold=%b want 10 1 1", lat, rd_low, hold_ok); failures++;
    end
    checks++;
  endtask

  task automatic test_read_hit();
    int lat, acks, oth; bit rd_low, hold_ok;
    model_hit = 1'b1; model_data = 16'h1234;
    do_access(1'b0, 1'b0, 25'h000208, 16'h0000, 2'b11, lat, acks, oth, rd_low, hold_ok);
    if (acks !== 1 || lat !== 4) begin
      $display("FAIL hit_latency: got acks=%0d lat=%0d want 1 4", acks, lat); failures++;
    end
    checks++;
    if (bus.a_dout !== 16'h1234) begin
      $display("FAIL hit_dout: got %h want 1234", bus.a_dout); failures++;
    end
    checks++;
  endtask

  task automatic test_write();
    int lat, acks, oth; bit rd_low, hold_ok;
    model_hit = 1'b0; model_lat = 8; model_data = 16'h5555;
    do_access(1'b1, 1'b1, 25'h1F0003, 16'h00A5, 2'b00, lat, acks, oth, rd_low, hold_ok);
    if (acks !== 1 || oth !== 0) begin
      $display("FAIL write_acks: got b=%0d a=%0d want 1 0", acks, oth); failures++;
    end
    checks++;
    if (!hold_ok || !rd_low || lat !== 10) begin
      $display("FAIL write_bus_hold: got hold=%b we_low=%b lat=%0d want 1 1 10", hold_ok, rd_low, lat); failures++;
    end
    checks++;
    if (bus.b_dout !== 16'h0000) begin
      $display("FAIL write_dout: got %h want 0000", bus.b_dout); failures++;
    end
    checks++;
  endtask

  task automatic test_contention();
    logic [4:0] seq, exp_seq;
    int n, extra;
    bit both;
    seq = '0; n = 0; extra = 0; both = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_seq = 5'b01011;
`else
    exp_seq = 5'b00001;
`endif
    model_hit = 1'b1; model_data = 16'h5A5A;
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = 25'h000010;
    bus.b_we = 1'b0; bus.b_addr = 25'h000020;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int i = 0; i < 200 && n < 5; i++) begin
      @(negedge clk);
      if (bus.a_ack && bus.b_ack) both = 1'b1;
      if (bus.a_ack || bus.b_ack) begin
        seq = {seq[3:0], bus.b_ack};
        n++;
        if (n == 4) bus.a_req = 1'b0;
        if (n == 5) bus.b_req = 1'b0;
      end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack) extra++;
    end
    if (n !== 5) begin
      $display("FAIL contention_timeout: got %0d acks want 5", n); failures++;
    end
    checks++;
    if (seq !== exp_seq) begin
      $display("FAIL contention_order: got %b want %b (1=B)", seq, exp_seq); failures++;
    end
    checks++;
    if (both || extra !== 0) begin
      $display("FAIL contention_extra_ack: got both=%b extra=%0d want 0 0", both, extra); failures++;
    end
    checks++;
    if (bus.a_dout !== 16'h5A5A || bus.b_dout !== 16'h5A5A) begin
      $display("FAIL contention_dout: got a=%h b=%h want 5a5a", bus.a_dout, bus.b_dout); failures++;
    end
    checks++;
  endtask

  task automatic test_async_reset();
    int lat, acks, oth, stale; bit rd_low, hold_ok, in_wait;
    stale = 0; in_wait = 1'b0;
    model_hit = 1'b0; model_lat = 8; model_data = 16'h7777;
    @(negedge clk);
    bus.a_we = 1'b0; bus.a_addr = 25'h000300; bus.a_req = 1'b1;
    for (int i = 0; i < 20 && !in_wait; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) in_wait = 1'b1;
    end
    if (!in_wait) begin
      $display("FAIL rst_reach_wait: got state=%0d want 2", dbg_state); failures++;
    end
    checks++;
    #2 reset_n = 1'b0;
    #1;
    if (bus.mem_rd !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL rst_strobe_drop: got mem_rd=%b state=%0d want 0 0", bus.mem_rd, dbg_state); failures++;
    end
    checks++;
    @(negedge clk);
    bus.a_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.a_ack || bus.b_ack || bus.mem_rd || bus.mem_we) stale++;
    end
    if (stale !== 0) begin
      $display("FAIL rst_stale_activity: got %0d cycles want 0", stale); failures++;
    end
    checks++;
    model_data = 16'hCAFE;
    do_access(1'b0, 1'b0, 25'h000400, 16'h0000, 2'b01, lat, acks, oth, rd_low, hold_ok);
    if (acks !== 1 || bus.a_dout !== 16'hCAFE || lat !== 10 || !hold_ok) begin
      $display("FAIL rst_next_access: got acks=%0d dout=%h lat=%0d hold=%b want 1 cafe 10 1",
               acks, bus.a_dout, lat, hold_ok);
      failures++;
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_startup_gating();
    test_read();
    test_read_hit();
    test_write();
    test_contention();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
